// File: rtl/bcd_ex3_pkg.sv
// Shared definitions for the packed-BCD to Excess-3 encoder:
// FSM state encoding and the digit-level code constants.
package bcd_ex3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] EX3_OFFSET  = 4'd3;
    localparam logic [3:0] EX3_INVALID = 4'd0;
    localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd2ex3_digit.sv
// Single-digit BCD to Excess-3 converter (purely combinational).
// Digits above 9 produce 4'b0000, which is not a legal Excess-3 code,
// and raise the invalid flag.
module bcd2ex3_digit
    import bcd_ex3_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] ex3,
    output logic       invalid
);

    // Add the Excess-3 offset to legal digits; substitute the marker code otherwise.
    always_comb begin
        invalid = (bcd > BCD_MAX);
        ex3     = invalid ? EX3_INVALID : (bcd + EX3_OFFSET);
    end

endmodule

// File: rtl/bcd_to_ex3_seq.sv
// Multi-digit packed-BCD to Excess-3 encoder.
// A word is accepted in IDLE, converted one digit per clock (LSB digit
// first) through one shared bcd2ex3_digit instance, then held in DONE
// until the downstream handshake.
// Optional build macro: BCD2EX3_ERRCNT_EN adds an 8-bit saturating count
// of completed results that carried an invalid digit (err_count port).
module bcd_to_ex3_seq
    import bcd_ex3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_ex3,
    output logic                out_err
`ifdef BCD2EX3_ERRCNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t           state_reg, state_next;
    logic [W-1:0]     src_reg, src_next;
    logic [W-1:0]     res_reg, res_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W-1:0]     out_ex3_reg, out_ex3_next;
    logic             out_err_reg, out_err_next;

    logic [3:0]       src_nib [DIGITS];
    logic [3:0]       cur_digit;
    logic [3:0]       cur_ex3;
    logic             cur_invalid;
    logic [W-1:0]     res_upd;

    // Split the source word into nibbles and build the result word with
    // only the nibble selected by the digit counter replaced.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign src_nib[gi]        = src_reg[4*gi +: 4];
            assign res_upd[4*gi +: 4] = (cnt_reg == CNT_W'(gi)) ? cur_ex3
                                                                : res_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_digit = src_nib[cnt_reg];

    bcd2ex3_digit u_digit (
        .bcd     (cur_digit),
        .ex3     (cur_ex3),
        .invalid (cur_invalid)
    );

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_ex3   = out_ex3_reg;
    assign out_err   = out_err_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath-update logic for all three states.
    always_comb begin
        state_next   = state_reg;
        src_next     = src_reg;
        res_next     = res_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        out_ex3_next = out_ex3_reg;
        out_err_next = out_err_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    src_next   = in_bcd;
                    res_next   = '0;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                res_next = res_upd;
                err_next = err_reg | cur_invalid;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    // Publish including the digit converted on this very edge.
                    out_ex3_next = res_upd;
                    out_err_next = err_reg | cur_invalid;
                    cnt_next     = '0;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: source, partial result, sticky error, counter, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg     <= '0;
            res_reg     <= '0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            out_ex3_reg <= '0;
            out_err_reg <= 1'b0;
        end else begin
            src_reg     <= src_next;
            res_reg     <= res_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            out_ex3_reg <= out_ex3_next;
            out_err_reg <= out_err_next;
        end
    end

`ifdef BCD2EX3_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    // Count delivered results flagged as erroneous, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (out_valid && out_ready && out_err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_bcd_to_ex3_seq.sv
// Directed bench for bcd_to_ex3_seq (DIGITS=4): a vector table applied in
// a loop, plus hand-written backpressure and mid-conversion reset sequences.
module tb_bcd_to_ex3_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bcd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_ex3;
    logic         out_err;
`ifdef BCD2EX3_ERRCNT_EN
    logic [7:0]   err_count;
    int           exp_cnt;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] bcd;
        logic [W-1:0] ex3;
        logic         err;
    } vec_t;

    vec_t vecs [8];

    bcd_to_ex3_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ex3   (out_ex3),
        .out_err   (out_err)
`ifdef BCD2EX3_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one word with out_ready low, measure latency, check result,
    // then perform the output handshake.
    task automatic run_word(input logic [W-1:0] bcd, input logic [W-1:0] ex3,
                            input logic err, input bit quiet);
        int lat;
        @(negedge clk);
        if (!quiet) chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_bcd    = bcd;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!quiet) chk("in_ready_conv", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!quiet) chk("latency", 32'(lat), 32'(DIGITS));
        chk("out_ex3", 32'(out_ex3), 32'(ex3));
        chk("out_err", 32'(out_err), 32'(err));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`ifdef BCD2EX3_ERRCNT_EN
        if (err && exp_cnt < 255) exp_cnt++;
        chk("err_count", 32'(err_count), 32'(exp_cnt));
`endif
        if (!quiet) chk("out_valid_after_hs", 32'(out_valid), 32'd0);
        $display("word bcd=%h ex3=%h err=%0d lat=%0d", bcd, out_ex3, out_err, lat);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{bcd: 16'h0000, ex3: 16'h3333, err: 1'b0};
        vecs[1] = '{bcd: 16'h9876, ex3: 16'hCBA9, err: 1'b0};
        vecs[2] = '{bcd: 16'h5432, ex3: 16'h8765, err: 1'b0};
        vecs[3] = '{bcd: 16'h12A4, ex3: 16'h4507, err: 1'b1};
        vecs[4] = '{bcd: 16'h0915, ex3: 16'h3C48, err: 1'b0};
        vecs[5] = '{bcd: 16'hFFFF, ex3: 16'h0000, err: 1'b1};
        vecs[6] = '{bcd: 16'h9999, ex3: 16'hCCCC, err: 1'b0};
        vecs[7] = '{bcd: 16'hB001, ex3: 16'h0334, err: 1'b1};
`ifdef BCD2EX3_ERRCNT_EN
        exp_cnt = 0;
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ex3", 32'(out_ex3), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].bcd, vecs[i].ex3, vecs[i].err, 1'b0);
        end

        // Backpressure: result held, new word refused while in DONE.
        @(negedge clk);
        in_bcd   = 16'h9876;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_bcd = 16'h5432;
        for (int i = 0; i < DIGITS; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ex3", 32'(out_ex3), 32'hCBA9);
            chk("bp_hold_err", 32'(out_err), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_idle", 32'(in_ready), 32'd1);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept", 32'(in_ready), 32'd0);
        for (int i = 0; i < DIGITS - 1; i++) begin
            @(posedge clk); #1;
            chk("bp_conv_busy", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_ex3", 32'(out_ex3), 32'h8765);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("backpressure sequence done ex3=%h", out_ex3);

        // Reset two cycles into conversion: asynchronous return to reset values.
        @(negedge clk);
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_ex3", 32'(out_ex3), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BCD2EX3_ERRCNT_EN
        exp_cnt = 0;
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        $display("mid-conversion reset applied");
        run_word(16'h0915, 16'h3C48, 1'b0, 1'b0);

`ifdef BCD2EX3_ERRCNT_EN
        for (int i = 0; i < 257; i++) begin
            run_word(16'h00F0, 16'h3303, 1'b1, 1'b1);
        end
        chk("err_count_sat", 32'(err_count), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
